// File: rtl/inst_seq_ctrl.sv
// Multi-cycle fetch / execute / retire sequencer for the NPC core.
// Drives instruction memory, holds the instruction register and retires addi/ebreak.
module inst_seq_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_inst,
   output logic [31:0] inst,
   input  logic        dec_is_addi,
   input  logic        dec_is_ebreak,
   output logic        rf_wen,
   output logic [63:0] pc,
   output logic [31:0] retire_cnt,
   output logic        halted,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_EXEC  = 3'd2,
      S_HALT  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] retire_q, retire_d;
   logic        halted_q, halted_d;
   logic        error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic [7:0]  tcnt_inc;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         inst_q     <= NOP_INST;
         retire_q   <= 32'd0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
         tcnt_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         retire_q   <= retire_d;
         halted_q   <= halted_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         tcnt_q     <= tcnt_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      retire_d   = retire_q;
      halted_d   = halted_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      tcnt_d     = tcnt_q;
      tcnt_inc   = tcnt_q + 8'd1;
      case (state_q)
         S_FETCH: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
               tcnt_d  = 8'd0;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WAIT: begin
            // A response arriving on the timeout cycle still wins
            if (imem_rsp_valid) begin
               inst_d  = imem_rsp_inst;
               state_d = S_EXEC;
            end else if (tcnt_inc == TIMEOUT_C) begin
               tcnt_d     = tcnt_inc;
               state_d    = S_ERR;
               error_d    = 1'b1;
               err_code_d = 2'b10;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         S_EXEC: begin
            if (dec_is_ebreak) begin
               halted_d = 1'b1;
               retire_d = retire_q + 32'd1;
               state_d  = S_HALT;
            end else if (dec_is_addi) begin
               pc_d     = pc_q + 64'd4;
               retire_d = retire_q + 32'd1;
               state_d  = S_FETCH;
            end else begin
               state_d    = S_ERR;
               error_d    = 1'b1;
               err_code_d = 2'b01;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // Handshake and write-enable outputs, suppressed while reset is applied
   always_comb begin
      imem_req_valid = 1'b0;
      rf_wen         = 1'b0;
      if (rst) begin
         imem_req_valid = 1'b0;
         rf_wen         = 1'b0;
      end else begin
         imem_req_valid = (state_q == S_FETCH);
         rf_wen         = (state_q == S_EXEC) && dec_is_addi && !dec_is_ebreak;
      end
   end

   assign imem_req_addr = pc_q;
   assign pc            = pc_q;
   assign inst          = inst_q;
   assign retire_cnt    = retire_q;
   assign halted        = halted_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign state         = state_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl: table-driven addi stream plus hand-written
// sequences for halt, back-pressure, timeout, illegal instruction and reset.
module tb_inst_seq_ctrl;

   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ILL    = 32'h0000_0033;
   localparam logic [63:0] RPC    = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_inst = 32'h0;
   logic [31:0] inst;
   logic        dec_is_addi;
   logic        dec_is_ebreak;
   logic        rf_wen;
   logic [63:0] pc;
   logic [31:0] retire_cnt;
   logic        halted;
   logic        error;
   logic [1:0]  err_code;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   // Reference decoder: addi is opcode 0010011 with funct3 000
   assign dec_is_addi   = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
   assign dec_is_ebreak = (inst == EBREAK);

   inst_seq_ctrl #(.RESET_PC(RPC), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_inst(imem_rsp_inst), .inst(inst),
      .dec_is_addi(dec_is_addi), .dec_is_ebreak(dec_is_ebreak),
      .rf_wen(rf_wen), .pc(pc), .retire_cnt(retire_cnt),
      .halted(halted), .error(error), .err_code(err_code), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ready;
      logic        rsp_v;
      logic [31:0] rsp_inst;
      logic [2:0]  st;
      logic        req_v;
      logic [63:0] addr;
      logic        wen;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   // Accept a fetch and return word w on the first WAIT cycle; ends in EXEC
   task automatic fetch_word(input logic [31:0] w);
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = w;
      cyc();
      imem_rsp_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         vecs[3*i]   = '{1'b1, 1'b0, 32'h0, 3'd0, 1'b1, RPC + 64'(4*i), 1'b0, 32'(i)};
         vecs[3*i+1] = '{1'b1, 1'b1, ADDI,  3'd1, 1'b0, RPC + 64'(4*i), 1'b0, 32'(i)};
         vecs[3*i+2] = '{1'b0, 1'b0, 32'h0, 3'd2, 1'b0, RPC + 64'(4*i), 1'b1, 32'(i)};
      end
      vecs[12] = '{1'b0, 1'b0, 32'h0, 3'd0, 1'b1, RPC + 64'd16, 1'b0, 32'd4};

      // Reset state, including outputs suppressed during the reset cycle
      rst = 1'b1;
      cyc();
      cyc();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_rf_wen", 64'(rf_wen), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_pc", pc, RPC);
      chk("rst_inst", 64'(inst), 64'h13);
      chk("rst_retire", 64'(retire_cnt), 64'd0);
      chk("rst_err", 64'({halted, error, err_code}), 64'd0);

      // Streaming addi vectors
      for (int j = 0; j < 13; j++) begin
         imem_req_ready = vecs[j].ready;
         imem_rsp_valid = vecs[j].rsp_v;
         imem_rsp_inst  = vecs[j].rsp_inst;
         chk($sformatf("vec%0d_state", j), 64'(state), 64'(vecs[j].st));
         chk($sformatf("vec%0d_req_v", j), 64'(imem_req_valid), 64'(vecs[j].req_v));
         chk($sformatf("vec%0d_addr", j), imem_req_addr, vecs[j].addr);
         chk($sformatf("vec%0d_wen", j), 64'(rf_wen), 64'(vecs[j].wen));
         chk($sformatf("vec%0d_ret", j), 64'(retire_cnt), 64'(vecs[j].ret));
         cyc();
      end
      imem_rsp_valid = 1'b0;

      // addi then ebreak halts with pc pointing at the ebreak
      do_reset();
      fetch_word(ADDI);
      cyc();
      fetch_word(EBREAK);
      chk("ebreak_wen", 64'(rf_wen), 64'd0);
      cyc();
      chk("halt_state", 64'(state), 64'd3);
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_pc", pc, RPC + 64'd4);
      chk("halt_retire", 64'(retire_cnt), 64'd2);
      begin
         int seen = 0;
         for (int k = 0; k < 20; k++) begin
            imem_req_ready = k[0];
            imem_rsp_valid = k[1];
            imem_rsp_inst  = ADDI;
            #1;
            if (imem_req_valid || rf_wen) seen++;
            cyc();
         end
         chk("halt_quiet", 64'(seen), 64'd0);
         chk("halt_frozen", 64'({state, retire_cnt}), {29'd0, 3'd3, 32'd2});
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;

      // Reset from HALT
      do_reset();
      #1;
      chk("rsthalt_state", 64'(state), 64'd0);
      chk("rsthalt_flags", 64'({halted, error, retire_cnt}), 64'd0);
      chk("rsthalt_pc", pc, RPC);

      // Back-pressure: ready low for 5 cycles
      for (int k = 0; k < 5; k++) begin
         chk("bp_req_v", 64'(imem_req_valid), 64'd1);
         chk("bp_addr", imem_req_addr, RPC);
         cyc();
         chk("bp_state", 64'(state), 64'd0);
      end
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      chk("bp_wait", 64'(state), 64'd1);

      // Timeout: 7 silent WAIT cycles still waiting, 8th goes to ERR
      begin
         int wen_seen = 0;
         for (int k = 0; k < 7; k++) begin
            if (rf_wen) wen_seen++;
            cyc();
         end
         chk("to_still_wait", 64'(state), 64'd1);
         cyc();
         chk("to_state", 64'(state), 64'd4);
         chk("to_err", 64'({error, err_code}), 64'b110);
         chk("to_wen", 64'(wen_seen + int'(rf_wen)), 64'd0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = ADDI;
      cyc();
      cyc();
      imem_rsp_valid = 1'b0;
      chk("to_ignore_state", 64'(state), 64'd4);
      chk("to_ignore_inst", 64'(inst), 64'h13);

      // Response on the final WAIT cycle beats the timeout
      do_reset();
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      for (int k = 0; k < 7; k++) cyc();
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = ADDI;
      cyc();
      imem_rsp_valid = 1'b0;
      chk("race_state", 64'(state), 64'd2);
      chk("race_err", 64'(error), 64'd0);

      // Illegal instruction after one addi
      do_reset();
      fetch_word(ADDI);
      cyc();
      fetch_word(ILL);
      cyc();
      chk("ill_state", 64'(state), 64'd4);
      chk("ill_err", 64'({error, err_code}), 64'b101);
      chk("ill_pc", pc, RPC + 64'd4);
      chk("ill_retire", 64'(retire_cnt), 64'd1);

      // Reset during WAIT, then a stale response in FETCH is ignored
      do_reset();
      fetch_word(ADDI);
      cyc();
      imem_req_ready = 1'b1;
      cyc();
      chk("rw_in_wait", 64'(state), 64'd1);
      do_reset();
      #1;
      chk("rw_state", 64'(state), 64'd0);
      chk("rw_pc", pc, RPC);
      chk("rw_retire", 64'(retire_cnt), 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = ILL;
      cyc();
      imem_rsp_valid = 1'b0;
      chk("stale_inst", 64'(inst), 64'h13);
      chk("stale_state", 64'(state), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
Multi-cycle control FSM that sequences the NPC core through fetch, decode/execute and retire around the instruction decoder. It issues instruction-memory requests and latches the returned word into an instruction register that drives the decoder. It consumes the decoder's is_addi/is_ebreak flags to pulse register-file write enable and advance the PC. It halts on ebreak and flags illegal instructions and fetch timeouts.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum WAIT cycles before a fetch timeout error (8-bit counter; legal range 1..255).

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  fetch address (= pc)
imem_rsp_valid  input  1  instruction word valid
imem_rsp_inst  input  32  instruction word
inst  output  32  latched instruction register, drives decoder inst input
dec_is_addi  input  1  decoder flag, combinational from inst
dec_is_ebreak  input  1  decoder flag, combinational from inst
rf_wen  output  1  one-cycle register-file write enable for addi retire
pc  output  64  current PC
retire_cnt  output  32  retired instruction count (addi + ebreak)
halted  output  1  sticky, set by ebreak
error  output  1  sticky, set by illegal instruction or timeout
err_code  output  2  01 = illegal instruction, 10 = fetch timeout, 00 = none
state  output  3  debug encoding: FETCH=0, WAIT=1, EXEC=2, HALT=3, ERR=4

Behaviour:
- Reset (rst=1 at posedge, any state):
  - state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), retire_cnt=0.
  - halted=0, error=0, err_code=00, timeout counter=0.
  - rf_wen=0, imem_req_valid=0 during the reset cycle.
  - An in-flight fetch is abandoned. A later rsp_valid is ignored unless state=WAIT.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid && imem_req_ready: go to WAIT, clear timeout counter.
  - Otherwise hold; addr stays stable while valid and not ready.
  - imem_rsp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst <= imem_rsp_inst, go to EXEC.
  - Otherwise counter++. When counter reaches TIMEOUT with no response: go to ERR, err_code=10.
  - rsp_valid and timeout in the same cycle: response wins.
- EXEC (exactly 1 cycle; decoder flags sampled this cycle):
  - dec_is_ebreak=1 (takes priority if both flags set): halted<=1, retire_cnt++, pc unchanged (points at ebreak), go to HALT. rf_wen=0.
  - Else dec_is_addi=1: rf_wen=1 combinationally this cycle only, pc<=pc+4 (64-bit wrap), retire_cnt++ (32-bit wrap), go to FETCH.
  - Else: go to ERR, err_code=01, pc unchanged, retire_cnt unchanged, rf_wen=0.
- HALT, ERR:
  - Terminal until reset.
  - imem_req_valid=0, rf_wen=0.
  - All registers frozen; handshake inputs ignored.
- rf_wen is asserted only in EXEC and never in any other state.
- Minimum latency per instruction: 3 cycles (FETCH accepted in 1 cycle, rsp on first WAIT cycle, EXEC).
- Throughput: one outstanding fetch; no pipelining.

Test Plan:
- Reset then ready=1 and rsp on the first WAIT cycle, streaming 4 words 32'h00100093 (addi) -> rf_wen pulses on cycles 3,6,9,12 after reset release; imem_req_addr = 0x80000000, 0x80000004, 0x80000008, 0x8000000C; retire_cnt=4.
- addi followed by 32'h00100073 (ebreak) -> halted=1, state=3, pc=0x80000004, retire_cnt=2; no imem_req_valid afterwards for 20 cycles.
- Hold ready=0 for 5 cycles in FETCH -> req_valid held at 1 with addr 0x80000000 stable; WAIT is entered only on the cycle ready=1.
- Response withheld with TIMEOUT=8 -> error=1, err_code=10 after 8 WAIT cycles; rf_wen never asserted. Then rsp_valid=1 arrives -> ignored.
- Fetch returns 32'h00000033 (both decoder flags 0) -> error=1, err_code=01, pc unchanged, retire_cnt unchanged.
- Assert rst during WAIT and during HALT -> next cycle state=0, pc=0x80000000, halted=0, error=0, retire_cnt=0; a stale rsp_valid in FETCH does not update inst.
